// File: rtl/pixel_timing_gen.sv
// Pixel timing generator: paces 8x8 pixel blocks with a programmable strobe
// period, counts completed blocks and finishes a block cleanly when run drops.
module pixel_timing_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             pix_en,
  output logic [2:0]       col,
  output logic [2:0]       row,
  output logic             block_start,
  output logic             block_end,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]   div_l_q, div_l_d;
  // Coordinates of the next pixel to be emitted
  logic [2:0]         pix_col_q, pix_col_d;
  logic [2:0]         pix_row_q, pix_row_d;
  // Registered outputs
  logic               pix_en_q, pix_en_d;
  logic [2:0]         col_q, col_d;
  logic [2:0]         row_q, row_d;
  logic               block_start_q, block_start_d;
  logic               block_end_q, block_end_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               busy_q, busy_d;

  logic               strobe;
  logic [DIV_W-1:0]   div_eff;

  // Next-state, pacing and pixel-advance logic
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    div_l_d   = div_l_q;
    pix_col_d = pix_col_q;
    pix_row_d = pix_row_q;
    strobe    = 1'b0;
    div_eff   = div_l_q;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d   = StRun;
          div_l_d   = div;
          phase_d   = '0;
          pix_col_d = '0;
          pix_row_d = '0;
        end
      end
      StRun, StStop: begin
        if (block_end_q && !run) begin
          state_d   = StIdle;
          phase_d   = '0;
          pix_col_d = '0;
          pix_row_d = '0;
        end else begin
          state_d = run ? StRun : StStop;
          // The block_end cycle already counts as phase 0 of the next block,
          // so the freshly latched period must drive this edge's compare.
          if (block_end_q) begin
            div_eff = div;
            div_l_d = div;
          end
          strobe  = (phase_q == div_eff);
          phase_d = strobe ? '0 : phase_q + DIV_W'(1);
          if (strobe) begin
            pix_col_d = pix_col_q + 3'd1;
            if (pix_col_q == 3'd7) begin
              pix_row_d = pix_row_q + 3'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register next values, derived from the strobe decision
  always_comb begin
    pix_en_d      = strobe;
    block_start_d = strobe && (pix_col_q == 3'd0) && (pix_row_q == 3'd0);
    block_end_d   = strobe && (pix_col_q == 3'd7) && (pix_row_q == 3'd7);
    col_d         = col_q;
    row_d         = row_q;
    if (strobe) begin
      col_d = pix_col_q;
      row_d = pix_row_q;
    end else if (state_d == StIdle) begin
      col_d = '0;
      row_d = '0;
    end
    blk_cnt_d = blk_cnt_q + CNT_W'(block_end_d);
    busy_d    = (state_d != StIdle);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      div_l_q       <= '0;
      pix_col_q     <= '0;
      pix_row_q     <= '0;
      pix_en_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      block_start_q <= 1'b0;
      block_end_q   <= 1'b0;
      blk_cnt_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      div_l_q       <= div_l_d;
      pix_col_q     <= pix_col_d;
      pix_row_q     <= pix_row_d;
      pix_en_q      <= pix_en_d;
      col_q         <= col_d;
      row_q         <= row_d;
      block_start_q <= block_start_d;
      block_end_q   <= block_end_d;
      blk_cnt_q     <= blk_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign col         = col_q;
  assign row         = row_q;
  assign block_start = block_start_q;
  assign block_end   = block_end_q;
  assign blk_cnt     = blk_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Self-checking bench for pixel_timing_gen against a pixel-index/countdown model.
module tb_pixel_timing_gen;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [7:0]    div = 8'd0;
  logic          pix_en;
  logic [2:0]    col;
  logic [2:0]    row;
  logic          block_start;
  logic          block_end;
  logic [CW-1:0] blk_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: block is "active" or not; pixels are numbered 0..63 and
  // each strobe fires when a countdown of (div+1) edges expires.
  bit            m_active;
  int            m_pix;
  int            m_cd;
  int            m_period;
  bit            m_last_end;
  logic          e_pix_en, e_bs, e_be, e_busy;
  logic [2:0]    e_col, e_row;
  logic [CW-1:0] e_cnt;

  pixel_timing_gen #(
    .DIV_W(8),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .div        (div),
    .pix_en     (pix_en),
    .col        (col),
    .row        (row),
    .block_start(block_start),
    .block_end  (block_end),
    .blk_cnt    (blk_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_pix = 0; m_cd = 0; m_period = 1; m_last_end = 0;
    e_pix_en = 0; e_bs = 0; e_be = 0; e_busy = 0; e_col = 0; e_row = 0; e_cnt = '0;
  endtask

  // Advance the model by one rising edge using the inputs sampled at it.
  task automatic model_step();
    e_pix_en = 0; e_bs = 0; e_be = 0;
    if (!m_active) begin
      e_col = 0; e_row = 0;
      if (run) begin
        m_active = 1; m_period = int'(div) + 1; m_cd = m_period; m_pix = 0;
      end
    end else if (m_last_end && !run) begin
      m_active = 0; e_col = 0; e_row = 0;
    end else begin
      if (m_last_end) begin
        m_period = int'(div) + 1;
        m_cd = m_period;
      end
      m_cd--;
      if (m_cd == 0) begin
        e_pix_en = 1;
        e_col = 3'(m_pix % 8);
        e_row = 3'(m_pix / 8);
        e_bs = (m_pix == 0);
        e_be = (m_pix == 63);
        if (e_be) e_cnt++;
        m_pix = (m_pix + 1) % 64;
        m_cd = m_period;
      end
    end
    e_busy = m_active;
    m_last_end = e_be;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    run = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    run = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({pix_en, block_start, block_end, busy, blk_cnt, row, col} !== '0) begin
      errors++;
      $display("FAIL reset: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp all zero",
               pix_en, block_start, block_end, busy, blk_cnt, row, col);
    end
    run = 0;
    rst = 0;
    model_reset();
  endtask

  task automatic test_div0();
    int n = 0;
    int be_at[$];
    do_reset();
    div = 0; run = 1;
    for (int i = 0; i < 130; i++) begin
      tick();
      checks++;
      if ({pix_en, block_start, block_end, busy, blk_cnt} !== {e_pix_en, e_bs, e_be, e_busy, e_cnt}
          || (e_pix_en && {row, col} !== {e_row, e_col})) begin
        errors++;
        $display("FAIL div0 cyc %0d: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp en%b bs%b be%b busy%b cnt%0d r%0d c%0d",
                 cyc, pix_en, block_start, block_end, busy, blk_cnt, row, col,
                 e_pix_en, e_bs, e_be, e_busy, e_cnt, e_row, e_col);
      end
      if (pix_en) n++;
      if (block_end) be_at.push_back(n);
    end
    checks++;
    if (n !== 129 || be_at.size() !== 2 || blk_cnt !== 2) begin
      errors++;
      $display("FAIL div0_summary: got strobes %0d ends %0d cnt %0d, exp 129 2 2", n, be_at.size(), blk_cnt);
    end else begin
      checks++;
      if (be_at[0] !== 64 || be_at[1] !== 128) begin
        errors++;
        $display("FAIL div0_end_pos: got %0d %0d, exp 64 128", be_at[0], be_at[1]);
      end
    end
  endtask

  task automatic test_div3();
    int n = 0, last = 0, bs_at = 0, be_at = 0;
    do_reset();
    div = 3; run = 1;
    tick();
    run = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++;
      if ({pix_en, block_start, block_end, busy, blk_cnt} !== {e_pix_en, e_bs, e_be, e_busy, e_cnt}
          || (e_pix_en && {row, col} !== {e_row, e_col})) begin
        errors++;
        $display("FAIL div3 cyc %0d: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp en%b bs%b be%b busy%b cnt%0d r%0d c%0d",
                 cyc, pix_en, block_start, block_end, busy, blk_cnt, row, col,
                 e_pix_en, e_bs, e_be, e_busy, e_cnt, e_row, e_col);
      end
      if (pix_en) begin
        n++;
        if (n > 1) begin
          checks++;
          if (cyc - last !== 4) begin
            errors++;
            $display("FAIL div3_spacing: got %0d, exp 4 at strobe %0d", cyc - last, n);
          end
        end
        last = cyc;
        if (block_start) bs_at = n;
        if (block_end) be_at = n;
      end
    end
    checks++;
    if (n !== 64 || bs_at !== 1 || be_at !== 64 || busy !== 1'b0 || blk_cnt !== 1) begin
      errors++;
      $display("FAIL div3_summary: got n%0d bs%0d be%0d busy%b cnt%0d, exp n64 bs1 be64 busy0 cnt1",
               n, bs_at, be_at, busy, blk_cnt);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    do_reset();
    div = 1; run = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      checks++;
      if ({pix_en, block_start, block_end, busy, blk_cnt} !== {e_pix_en, e_bs, e_be, e_busy, e_cnt}
          || (e_pix_en && {row, col} !== {e_row, e_col})) begin
        errors++;
        $display("FAIL stop cyc %0d: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp en%b bs%b be%b busy%b cnt%0d r%0d c%0d",
                 cyc, pix_en, block_start, block_end, busy, blk_cnt, row, col,
                 e_pix_en, e_bs, e_be, e_busy, e_cnt, e_row, e_col);
      end
      if (pix_en) begin
        n++;
        if (n == 20) run = 0;
      end
    end
    checks++;
    if (n - 20 !== 44 || blk_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_summary: got after-drop %0d cnt %0d busy %b, exp 44 1 0", n - 20, blk_cnt, busy);
    end
  endtask

  task automatic test_div_change();
    int n = 0, last = 0, want;
    do_reset();
    div = 0; run = 1;
    for (int i = 0; i < 160; i++) begin
      tick();
      checks++;
      if ({pix_en, block_start, block_end, busy, blk_cnt} !== {e_pix_en, e_bs, e_be, e_busy, e_cnt}
          || (e_pix_en && {row, col} !== {e_row, e_col})) begin
        errors++;
        $display("FAIL divchg cyc %0d: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp en%b bs%b be%b busy%b cnt%0d r%0d c%0d",
                 cyc, pix_en, block_start, block_end, busy, blk_cnt, row, col,
                 e_pix_en, e_bs, e_be, e_busy, e_cnt, e_row, e_col);
      end
      if (pix_en) begin
        n++;
        if (n > 1) begin
          want = (n <= 64) ? 1 : 3;
          checks++;
          if (cyc - last !== want) begin
            errors++;
            $display("FAIL divchg_spacing: got %0d, exp %0d at strobe %0d", cyc - last, want, n);
          end
        end
        last = cyc;
        if (n == 10) div = 2;
      end
    end
  endtask

  task automatic test_async_rst();
    int n = 0;
    bit seen_first = 0;
    do_reset();
    div = 1; run = 1;
    for (int i = 0; i < 200 && n < 30; i++) begin
      tick();
      if (pix_en) n++;
    end
    checks++;
    if (n !== 30) begin
      errors++;
      $display("FAIL arst_reach: got %0d strobes, exp 30", n);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({pix_en, block_start, block_end, busy, blk_cnt, row, col} !== '0) begin
      errors++;
      $display("FAIL arst_zero: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp all zero",
               pix_en, block_start, block_end, busy, blk_cnt, row, col);
    end
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({pix_en, block_start, block_end, busy, blk_cnt} !== {e_pix_en, e_bs, e_be, e_busy, e_cnt}
          || (e_pix_en && {row, col} !== {e_row, e_col})) begin
        errors++;
        $display("FAIL arst cyc %0d: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp en%b bs%b be%b busy%b cnt%0d r%0d c%0d",
                 cyc, pix_en, block_start, block_end, busy, blk_cnt, row, col,
                 e_pix_en, e_bs, e_be, e_busy, e_cnt, e_row, e_col);
      end
      if (pix_en && !seen_first) begin
        seen_first = 1;
        checks++;
        if ({row, col, block_start} !== 7'b0000001) begin
          errors++;
          $display("FAIL arst_restart: got r%0d c%0d bs%b, exp r0 c0 bs1", row, col, block_start);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int k = 0;
    do_reset();
    div = 0; run = 1;
    for (int i = 0; i < 400 && k < 5; i++) begin
      tick();
      if (block_end) begin
        checks++;
        if (blk_cnt !== seq[k]) begin
          errors++;
          $display("FAIL wrap block %0d: got cnt %0d, exp %0d", k + 1, blk_cnt, seq[k]);
        end
        k++;
      end
    end
    checks++;
    if (k !== 5) begin
      errors++;
      $display("FAIL wrap_count: got %0d block ends, exp 5", k);
    end
  endtask

  task automatic test_random();
    do_reset();
    div = 8'($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) run = ~run;
      if ($urandom_range(0, 9) == 0) div = 8'($urandom_range(0, 3));
      tick();
      checks++;
      if ({pix_en, block_start, block_end, busy, blk_cnt} !== {e_pix_en, e_bs, e_be, e_busy, e_cnt}
          || (e_pix_en && {row, col} !== {e_row, e_col})) begin
        errors++;
        $display("FAIL random cyc %0d: got en%b bs%b be%b busy%b cnt%0d r%0d c%0d, exp en%b bs%b be%b busy%b cnt%0d r%0d c%0d",
                 cyc, pix_en, block_start, block_end, busy, blk_cnt, row, col,
                 e_pix_en, e_bs, e_be, e_busy, e_cnt, e_row, e_col);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_div0();
    test_div3();
    test_stop();
    test_div_change();
    test_async_rst();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_timing_gen.md
PIXEL_TIMING_GEN -- requirements
Module: pixel_timing_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning the width of the pixel-strobe divider input.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the completed-block counter.
REQ-003 SHALL have port clk  input  1  free-running simulation/system clock, rising-edge active; this is the single clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port run  input  1  level request to generate 8x8 pixel blocks.
REQ-006 SHALL have port div  input  DIV_W  strobe period minus one, in clk cycles.
REQ-007 SHALL have port pix_en  output  1  one-cycle pixel strobe.
REQ-008 SHALL have port col  output  3  pixel column within the block; valid when pix_en=1.
REQ-009 SHALL have port row  output  3  pixel row within the block; valid when pix_en=1.
REQ-010 SHALL have port block_start  output  1  high with the pix_en of pixel (row 0, col 0).
REQ-011 SHALL have port block_end  output  1  high with the pix_en of pixel (row 7, col 7).
REQ-012 SHALL have port blk_cnt  output  CNT_W  number of completed blocks.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, STOP.
REQ-015 SHALL go IDLE->RUN on a rising clk edge that samples run=1 in IDLE; at that edge it latches div into div_l and clears phase, col and row.
REQ-016 SHALL count phase from 0 to div_l in RUN and STOP, wrapping to 0; pix_en SHALL be high exactly in cycles where phase==div_l.
REQ-017 SHALL make the first pix_en high in the cycle following the (div_l+1)th rising edge after the IDLE->RUN edge (div=0: strobe on every cycle, starting one cycle after entering RUN).
REQ-018 SHALL advance on each pix_en: col+1; col 7->0 with row+1; (row 7, col 7)->(0,0).
REQ-019 SHALL increment blk_cnt on each block_end, wrapping from all-ones to 0.
REQ-020 SHALL re-latch div only at a block boundary (the edge ending the block_end cycle); changes to div mid-block SHALL have no effect on the current block.
REQ-021 SHALL go RUN->STOP when run=0 is sampled mid-block; STOP SHALL finish the current block at unchanged pacing.
REQ-022 SHALL go RUN or STOP->IDLE at the edge ending a block_end cycle if run=0 is sampled at that edge; if run=1 is sampled at that edge, the next state SHALL be RUN with no idle gap.
REQ-023 SHALL return STOP->RUN if run=1 is sampled before block_end, with no disturbance to counters.
REQ-024 SHALL keep pix_en, block_start and block_end low in IDLE; col and row SHALL hold 0 in IDLE.
REQ-025 SHALL register every output; no output SHALL depend combinationally on run or div.

Reset
REQ-026 SHALL on rst=1, immediately and regardless of clk: state IDLE, phase 0, div_l 0, col 0, row 0, pix_en 0, block_start 0, block_end 0, blk_cnt 0, busy 0.
REQ-027 SHALL abandon a block in progress on rst mid-block without incrementing blk_cnt.
REQ-028 SHALL sample run no earlier than the first rising edge after rst deasserts.

Verification
REQ-029 SHALL pass: div=0, run held 1 for 130 cycles -> pix_en high every cycle after start, block_end at pixels 64 and 128, blk_cnt=2.
REQ-030 SHALL pass: div=3, one block -> pix_en spacing 4 cycles, 64 strobes, block_start on the 1st, block_end on the 64th, busy low after the block.
REQ-031 SHALL pass: run dropped after pixel 20 -> remaining 44 pixels emitted, then IDLE, blk_cnt=1.
REQ-032 SHALL pass: div changed 0->2 at pixel 10 -> current block stays at 1-cycle spacing, next block uses 3-cycle spacing.
REQ-033 SHALL pass: rst pulsed asynchronously (between edges) at pixel 30 -> all outputs 0 at once, blk_cnt=0, restart begins at (0,0).
REQ-034 SHALL pass: with CNT_W=2, 5 blocks -> blk_cnt sequence 1,2,3,0,1.
